// File: rtl/unfold_pkg.sv
// ---------------------------------------------------------------------------
// unfold_pkg
// Shared definitions for the 3-way unfolded sample sequencer.
//   UNFOLD     : number of samples per parallel group
//   phase_t    : 2-bit group phase (0..UNFOLD-1)
//   triple_t   : one group of three samples at the default 16-bit width,
//                field k0 = sample 3k (oldest) .. k2 = sample 3k+2 (newest)
//   next_phase : modulo-UNFOLD phase increment
// ---------------------------------------------------------------------------
package unfold_pkg;

    localparam int UNFOLD   = 3;
    localparam int NBIT_DEF = 16;

    typedef logic [1:0] phase_t;

    typedef struct packed {
        logic [NBIT_DEF-1:0] k0;
        logic [NBIT_DEF-1:0] k1;
        logic [NBIT_DEF-1:0] k2;
    } triple_t;

    function automatic phase_t next_phase(input phase_t p);
        return (p == phase_t'(UNFOLD - 1)) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/unfold_seq_triple_fifo.sv
// ---------------------------------------------------------------------------
// triple_fifo
// Synchronous DEPTH-entry FIFO holding one packed triple per entry. A push
// while full is accepted only when a pop happens in the same cycle.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr          : synchronous flush (pointers to zero)
//   push, wdata  : write request and data
//   pop          : read request (ignored when empty)
//   rdata        : head entry, valid while !empty
//   full, empty  : occupancy flags
// ---------------------------------------------------------------------------
module triple_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are
    // valid, so resetting the array would only cost flops and routing.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/unfold_seq.sv
// ---------------------------------------------------------------------------
// unfold_seq
// Sample sequencer around a 3-way unfolded filter: packs the serial input
// into triples for the filter and re-serialises the filter's result triples.
// Optional build macro: UNFOLD_SEQ_OVF_CNT_EN adds the OVF_CNT port and an
// 8-bit saturating dropped-triple counter.
// Ports:
//   CLK, RST_n          : clock, asynchronous active-low reset
//   CLR                 : synchronous clear of packer, buffer and unpacker
//   DIN, VIN            : serial input sample / valid (no backpressure)
//   F_DIN3k..F_DIN3k2   : to filter, oldest..newest sample of a group
//   F_VIN               : to filter, one-cycle group valid
//   F_DOUT3k..F_DOUT3k2 : from filter, result triple
//   F_VOUT              : from filter, result triple valid
//   DOUT, VOUT, OUT_RDY : serial ready/valid output
//   OVF                 : sticky, a result triple was dropped
//   OVF_CNT             : dropped-triple count (macro build only)
// ---------------------------------------------------------------------------
module unfold_seq
    import unfold_pkg::*;
#(
    parameter int NBIT   = 16,
    parameter int ODEPTH = 4
) (
    input  logic            CLK,
    input  logic            RST_n,
    input  logic            CLR,
    input  logic [NBIT-1:0] DIN,
    input  logic            VIN,
    output logic [NBIT-1:0] F_DIN3k,
    output logic [NBIT-1:0] F_DIN3k1,
    output logic [NBIT-1:0] F_DIN3k2,
    output logic            F_VIN,
    input  logic [NBIT-1:0] F_DOUT3k,
    input  logic [NBIT-1:0] F_DOUT3k1,
    input  logic [NBIT-1:0] F_DOUT3k2,
    input  logic            F_VOUT,
    output logic [NBIT-1:0] DOUT,
    output logic            VOUT,
    input  logic            OUT_RDY,
    output logic            OVF
`ifdef UNFOLD_SEQ_OVF_CNT_EN
    ,
    output logic [7:0]      OVF_CNT
`endif
);

    typedef struct packed {
        logic [NBIT-1:0] k0;
        logic [NBIT-1:0] k1;
        logic [NBIT-1:0] k2;
    } trip_t;

    phase_t          iph;
    phase_t          oph;
    logic [NBIT-1:0] s0;
    logic [NBIT-1:0] s1;
    trip_t           head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            xfer;
    logic            pop;
    logic            push;
    logic            drop;

    // ---------------- packer ----------------
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            iph      <= '0;
            s0       <= '0;
            s1       <= '0;
            F_DIN3k  <= '0;
            F_DIN3k1 <= '0;
            F_DIN3k2 <= '0;
            F_VIN    <= 1'b0;
        end else if (CLR) begin
            iph   <= '0;
            F_VIN <= 1'b0;
        end else begin
            F_VIN <= 1'b0;
            if (VIN) begin
                unique case (iph)
                    2'd0: s0 <= DIN;
                    2'd1: s1 <= DIN;
                    2'd2: begin
                        F_DIN3k  <= s0;
                        F_DIN3k1 <= s1;
                        F_DIN3k2 <= DIN;
                        F_VIN    <= 1'b1;
                    end
                    default: ;
                endcase
                iph <= next_phase(iph);
            end
        end
    end

    // ---------------- buffer ----------------
    // A transfer is only possible while VOUT is high, i.e. the FIFO holds data,
    // so pop never targets an empty FIFO. CLR masks every same-cycle event.
    assign xfer = VOUT && OUT_RDY && !CLR;
    assign pop  = xfer && (oph == phase_t'(UNFOLD - 1));
    assign push = F_VOUT && !CLR;
    assign drop = push && fifo_full && !pop;

    triple_fifo #(
        .WIDTH (UNFOLD * NBIT),
        .DEPTH (ODEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_n),
        .clr   (CLR),
        .push  (push),
        .wdata ({F_DOUT3k, F_DOUT3k1, F_DOUT3k2}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            OVF <= 1'b0;
        end else if (drop) begin
            OVF <= 1'b1;
        end
    end

`ifdef UNFOLD_SEQ_OVF_CNT_EN
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            OVF_CNT <= '0;
        end else if (drop && (OVF_CNT != 8'hFF)) begin
            OVF_CNT <= OVF_CNT + 8'd1;
        end
    end
`endif

    // ---------------- unpacker ----------------
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            oph <= '0;
        end else if (CLR) begin
            oph <= '0;
        end else if (xfer) begin
            oph <= next_phase(oph);
        end
    end

    assign VOUT = !fifo_empty;

    // NOTE: every combinational output gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        DOUT = '0;
        if (!fifo_empty) begin
            unique case (oph)
                2'd0:    DOUT = head.k0;
                2'd1:    DOUT = head.k1;
                2'd2:    DOUT = head.k2;
                default: DOUT = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_unfold_seq.sv
// ---------------------------------------------------------------------------
// tb_unfold_seq
// Directed bench for unfold_seq (NBIT = 16, ODEPTH = 4). A small reference
// model tracks input phase, buffered triples and output phase; expected
// filter groups and expected serial samples are queued when stimulus is
// applied and compared when the DUT presents them.
// ---------------------------------------------------------------------------
module tb_unfold_seq;
    import unfold_pkg::*;

    localparam int NBIT   = 16;
    localparam int ODEPTH = 4;

    logic            CLK = 1'b0;
    logic            RST_n;
    logic            CLR;
    logic [NBIT-1:0] DIN;
    logic            VIN;
    logic [NBIT-1:0] F_DIN3k, F_DIN3k1, F_DIN3k2;
    logic            F_VIN;
    logic [NBIT-1:0] F_DOUT3k, F_DOUT3k1, F_DOUT3k2;
    logic            F_VOUT;
    logic [NBIT-1:0] DOUT;
    logic            VOUT;
    logic            OUT_RDY;
    logic            OVF;
`ifdef UNFOLD_SEQ_OVF_CNT_EN
    logic [7:0]      OVF_CNT;
`endif

    unfold_seq #(.NBIT(NBIT), .ODEPTH(ODEPTH)) dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .CLR       (CLR),
        .DIN       (DIN),
        .VIN       (VIN),
        .F_DIN3k   (F_DIN3k),
        .F_DIN3k1  (F_DIN3k1),
        .F_DIN3k2  (F_DIN3k2),
        .F_VIN     (F_VIN),
        .F_DOUT3k  (F_DOUT3k),
        .F_DOUT3k1 (F_DOUT3k1),
        .F_DOUT3k2 (F_DOUT3k2),
        .F_VOUT    (F_VOUT),
        .DOUT      (DOUT),
        .VOUT      (VOUT),
        .OUT_RDY   (OUT_RDY),
        .OVF       (OVF)
`ifdef UNFOLD_SEQ_OVF_CNT_EN
        ,
        .OVF_CNT   (OVF_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // reference model state
    triple_t         f_q[$];
    logic [NBIT-1:0] o_q[$];
    int              m_iph, m_oph, m_cnt, m_ovfcnt;
    logic            m_ovf;
    logic [NBIT-1:0] m_s0, m_s1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        f_q.delete();
        o_q.delete();
        m_iph = 0; m_oph = 0; m_cnt = 0; m_ovfcnt = 0;
        m_ovf = 1'b0; m_s0 = '0; m_s1 = '0;
    endtask

    // One clock: check serial output before the edge, advance the model with
    // the inputs present at the edge, then check filter-side and flag outputs.
    task automatic tick();
        logic fvin_exp;
        logic xfer_m, pop_m;
        triple_t t;
        fvin_exp = 1'b0;
        chk("vout", VOUT, (m_cnt != 0));
        if (m_cnt != 0) chk("dout", DOUT, o_q[0]);
        else            chk("dout_idle", DOUT, 0);

        if (CLR) begin
            f_q.delete();
            o_q.delete();
            m_iph = 0; m_oph = 0; m_cnt = 0;
        end else begin
            if (VIN) begin
                case (m_iph)
                    0: m_s0 = DIN;
                    1: m_s1 = DIN;
                    default: begin
                        t.k0 = m_s0; t.k1 = m_s1; t.k2 = DIN;
                        f_q.push_back(t);
                        fvin_exp = 1'b1;
                    end
                endcase
                m_iph = (m_iph + 1) % 3;
            end
            xfer_m = (m_cnt != 0) && OUT_RDY;
            pop_m  = xfer_m && (m_oph == 2);
            if (xfer_m) begin
                void'(o_q.pop_front());
                m_oph = (m_oph + 1) % 3;
            end
            if (F_VOUT) begin
                if (m_cnt < ODEPTH || pop_m) begin
                    o_q.push_back(F_DOUT3k);
                    o_q.push_back(F_DOUT3k1);
                    o_q.push_back(F_DOUT3k2);
                    m_cnt++;
                end else begin
                    m_ovf = 1'b1;
                    if (m_ovfcnt < 255) m_ovfcnt++;
                end
            end
            if (pop_m) m_cnt--;
        end

        @(posedge CLK);
        #1;
        chk("f_vin", F_VIN, fvin_exp);
        if (F_VIN === 1'b1 && f_q.size() != 0) begin
            t = f_q.pop_front();
            chk("f_din3k",  F_DIN3k,  t.k0);
            chk("f_din3k1", F_DIN3k1, t.k1);
            chk("f_din3k2", F_DIN3k2, t.k2);
        end
        chk("ovf", OVF, m_ovf);
`ifdef UNFOLD_SEQ_OVF_CNT_EN
        chk("ovf_cnt", OVF_CNT, m_ovfcnt);
`endif
    endtask

    task automatic sample(input logic [NBIT-1:0] d);
        VIN = 1'b1; DIN = d;
        tick();
        VIN = 1'b0;
    endtask

    task automatic fres(input logic [NBIT-1:0] a, input logic [NBIT-1:0] b,
                        input logic [NBIT-1:0] c);
        F_VOUT = 1'b1; F_DOUT3k = a; F_DOUT3k1 = b; F_DOUT3k2 = c;
        tick();
        F_VOUT = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        RST_n = 1'b0; CLR = 1'b0; DIN = '0; VIN = 1'b0;
        F_DOUT3k = '0; F_DOUT3k1 = '0; F_DOUT3k2 = '0; F_VOUT = 1'b0;
        OUT_RDY = 1'b1;
        model_reset();

        // reset state
        #12;
        chk("rst_f_vin", F_VIN, 0);
        chk("rst_f_din3k", F_DIN3k, 0);
        chk("rst_f_din3k2", F_DIN3k2, 0);
        chk("rst_vout", VOUT, 0);
        chk("rst_dout", DOUT, 0);
        chk("rst_ovf", OVF, 0);
        @(negedge CLK);
        RST_n = 1'b1;
        @(posedge CLK); #1;

        // pack: six back-to-back samples -> two groups
        for (int i = 1; i <= 6; i++) sample(NBIT'(i));
        idle(2);

        // gapped input
        sample(16'd10); idle(2);
        sample(16'd11); idle(1);
        sample(16'd12); idle(2);

        // unpack
        fres(16'd7, 16'd8, 16'd9);
        idle(5);

        // backpressure mid-triple
        fres(16'd30, 16'd31, 16'd32);
        tick();
        OUT_RDY = 1'b0;
        idle(5);
        OUT_RDY = 1'b1;
        idle(4);

        // overflow: five triples with the sink stalled
        OUT_RDY = 1'b0;
        for (int i = 0; i < 5; i++)
            fres(NBIT'(16'h100 + 16*i), NBIT'(16'h101 + 16*i), NBIT'(16'h102 + 16*i));
        chk("ovf_set", OVF, 1);
        OUT_RDY = 1'b1;
        idle(14);
        chk("drain_empty", o_q.size(), 0);

        // full FIFO with a same-cycle pop accepts the push
        OUT_RDY = 1'b0;
        for (int i = 0; i < 4; i++)
            fres(NBIT'(16'h200 + 16*i), NBIT'(16'h201 + 16*i), NBIT'(16'h202 + 16*i));
        OUT_RDY = 1'b1;
        idle(2);
        fres(16'h2A0, 16'h2A1, 16'h2A2);
        idle(16);
        chk("full_pop_drained", o_q.size(), 0);

        // back-to-back stream, one triple every three cycles, no bubbles
        for (int i = 0; i < 4; i++) begin
            fres(NBIT'(16'h300 + 16*i), NBIT'(16'h301 + 16*i), NBIT'(16'h302 + 16*i));
            idle(2);
        end
        idle(3);

        // CLR with a partial group and a buffered triple
        OUT_RDY = 1'b0;
        sample(16'd40);
        sample(16'd41);
        fres(16'd50, 16'd51, 16'd52);
        CLR = 1'b1; VIN = 1'b1; DIN = 16'd99; F_VOUT = 1'b1;
        tick();
        CLR = 1'b0; VIN = 1'b0; F_VOUT = 1'b0;
        OUT_RDY = 1'b1;
        chk("clr_vout", VOUT, 0);
        sample(16'd20);
        sample(16'd21);
        sample(16'd22);
        idle(2);
        chk("clr_ovf_kept", OVF, 1);

        // asynchronous reset mid-stream
        sample(16'd60);
        fres(16'd61, 16'd62, 16'd63);
        #2;
        RST_n = 1'b0;
        #1;
        chk("arst_vout", VOUT, 0);
        chk("arst_dout", DOUT, 0);
        chk("arst_ovf", OVF, 0);
        chk("arst_f_din3k1", F_DIN3k1, 0);
        model_reset();
        @(negedge CLK);
        RST_n = 1'b1;
        @(posedge CLK); #1;
        sample(16'd70); sample(16'd71); sample(16'd72);
        idle(2);

        chk("fq_empty", f_q.size(), 0);
        chk("oq_empty", o_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/unfold_seq.md
# unfold_seq

Sample sequencer for the 3-way unfolded IIR filter (`myfilter`). It packs a serial one-sample-per-cycle input stream into groups of three and issues each group as one parallel `DIN3k/DIN3k1/DIN3k2` word with a single-cycle `VIN`. It buffers the parallel `DOUT3k/DOUT3k1/DOUT3k2` results and re-serialises them to a ready/valid output. The block sits between `data_maker`-style serial sources and `data_sink`-style serial sinks; the filter itself is instantiated outside it.

## Interface
Parameters:
- NBIT, 16, sample width (two's complement; opaque to this block)
- ODEPTH, 4, output buffer depth in triples; power of two, ≥2

Ports:
- CLK  in  1  clock, rising edge
- RST_n  in  1  asynchronous active-low reset
- CLR  in  1  synchronous clear: drops partial input group and empties output buffer
- DIN  in  NBIT  serial input sample
- VIN  in  1  DIN valid (no backpressure toward source)
- F_DIN3k / F_DIN3k1 / F_DIN3k2  out  NBIT each  to filter: oldest, middle, newest sample of group
- F_VIN  out  1  to filter: group valid, one-cycle pulse
- F_DOUT3k / F_DOUT3k1 / F_DOUT3k2  in  NBIT each  from filter
- F_VOUT  in  1  from filter: result triple valid
- DOUT  out  NBIT  serial output sample
- VOUT  out  1  DOUT valid
- OUT_RDY  in  1  sink ready; a sample transfers on VOUT & OUT_RDY
- OVF  out  1  sticky: a result triple was dropped
- OVF_CNT  out  8  dropped-triple count (only with OVF_CNT_EN)

## Operation
- Reset values: F_DIN* = 0, F_VIN = 0, DOUT = 0, VOUT = 0, OVF = 0, OVF_CNT = 0. Input phase is 0 and the buffer is empty.
- **Packer.** 2-bit input phase `iph` cycles 0→1→2→0, advancing only on VIN.
  - iph = 0: store DIN in s0.
  - iph = 1: store DIN in s1.
  - iph = 2: register F_DIN3k = s0, F_DIN3k1 = s1, F_DIN3k2 = DIN, and F_VIN = 1.
  - F_VIN is 0 in every other cycle. F_DIN* hold their last value when F_VIN = 0.
- **Buffer.** ODEPTH-entry FIFO of triples.
  - F_VOUT pushes {F_DOUT3k, F_DOUT3k1, F_DOUT3k2}.
  - Full with no pop in the same cycle: the triple is dropped, OVF is set, and OVF_CNT increments (saturates at 255).
  - Full with a pop in the same cycle: the push is accepted.
- **Unpacker.** 2-bit output phase `oph`.
  - FIFO non-empty: VOUT = 1 and DOUT = head[oph], driven directly from registers, with order 3k, 3k1, 3k2.
  - On each transfer, `oph` advances. The transfer at `oph` = 2 pops the head and returns `oph` to 0.
  - FIFO empty: VOUT = 0 and DOUT = 0.
- **CLR.** Same cycle effects: `iph` = 0, FIFO empty, `oph` = 0, VOUT = 0 next cycle, F_VIN = 0 next cycle.
  - VIN, F_VOUT and any transfer coinciding with CLR are ignored.
  - OVF and OVF_CNT are not cleared by CLR; only RST_n clears them.
- **Reset mid-group.** Asynchronous RST_n discards partial groups and buffered triples immediately.

## Timing
- Packer latency: third sample accepted at edge t → F_VIN = 1 in the cycle after edge t (one cycle).
- Buffer latency: F_VOUT sampled at edge t → VOUT = 1 with DOUT = F_DOUT3k in the cycle after edge t.
- Unpacker throughput: one sample per cycle while OUT_RDY = 1. Back-to-back triples stream with no bubble.
- OUT_RDY may drop at any time. DOUT and VOUT stay stable until transfer.
- Filter-to-input latency is outside this block. The block only requires that F_VOUT pulses are at least 3 cycles apart on average for lossless operation at full sink rate.

## Configuration
- `UNFOLD_SEQ_OVF_CNT_EN` defined: the OVF_CNT port and an 8-bit saturating counter exist.
- Not defined: the port and counter are absent. OVF, the sticky flag, is always present.

## Structure
- Package `unfold_pkg` holds:
  - the `UNFOLD = 3` constant
  - the `phase_t` (2-bit) typedef
  - the `triple_t` typedef: a packed struct of three NBIT samples, with NBIT default 16
- Sub-module `triple_fifo` implements the synchronous ODEPTH-deep triple FIFO with push, pop, full and empty, and simultaneous push/pop when full. Packer, unpacker and overflow logic stay in `unfold_seq`.

## Test plan
- **Pack:** VIN = 1 for DIN = 1, 2, 3, 4, 5, 6 → F_VIN pulses twice, carrying (1, 2, 3) and (4, 5, 6), each one cycle after samples 3 and 6.
- **Gapped input:** samples 10, 11, 12 with VIN low between them → exactly one F_VIN pulse, carrying (10, 11, 12).
- **Unpack:** F_VOUT with (7, 8, 9), OUT_RDY = 1 → DOUT = 7, 8, 9 on three consecutive cycles with VOUT = 1, then VOUT = 0.
- **Backpressure:** OUT_RDY = 0 for 5 cycles mid-triple → DOUT holds its value, no loss, and the sequence resumes in order.
- **Overflow:** OUT_RDY = 0 and 5 F_VOUT pulses with ODEPTH = 4 → the 5th triple is dropped, OVF = 1, OVF_CNT = 1; draining yields exactly the first 4 triples.
- **CLR / reset mid-operation:** CLR after 2 input samples and 1 buffered triple → the next samples 20, 21, 22 produce F_VIN with (20, 21, 22), VOUT = 0 until new data arrives, and OVF is unchanged. RST_n low mid-stream → all outputs are 0 asynchronously.
